command_sender: RTL and testbench

COMMAND_SENDER -- requirements
Module: command_sender

---
 rtl/command_sender.sv | 168 ++++++++++++++++
 tb/tb_command_sender.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/command_sender.sv
// command_sender: sends one 8-bit LCD command as two 4-bit transfers, upper nibble first.
// Each nibble gets a setup phase, an enable pulse and a hold phase. A gap separates the
// two nibbles, and a long wait follows the second one before the next command can start.
//
// Ports:
//   clk      system clock; all state changes on the rising edge
//   rst      synchronous active-high reset
//   start    request to send one command; accepted only while ready=1
//   rs_in    register select captured with the command (0 = instruction, 1 = data)
//   rw_in    read/write select captured with the command
//   data_in  command byte, captured on the accepting edge
//   lcd_rs   LCD register select (registered)
//   lcd_rw   LCD read/write (registered)
//   lcd_e    LCD enable strobe (registered)
//   sf_d     LCD data nibble (registered)
//   ready    high while idle and able to accept start (registered)
module command_sender #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 50,
  parameter int unsigned T_WAIT  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] sf_d,
  output logic       ready
);

  localparam int unsigned CntW = 12;

  // Counter value on the final cycle of each phase.
  localparam logic [CntW-1:0] SetupLast = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(T_GAP - 1);
  localparam logic [CntW-1:0] WaitLast  = CntW'(T_WAIT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StUSetup,
    StUPulse,
    StUHold,
    StGap,
    StLSetup,
    StLPulse,
    StLHold,
    StWait
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      lo_nibble_q;
  logic            phase_done;

  // True on the last cycle of the current timed phase.
  always_comb begin
    phase_done = 1'b0;
    unique case (state_q)
      StUSetup, StLSetup: phase_done = (cnt_q == SetupLast);
      StUPulse, StLPulse: phase_done = (cnt_q == PulseLast);
      StUHold, StLHold:   phase_done = (cnt_q == HoldLast);
      StGap:              phase_done = (cnt_q == GapLast);
      StWait:             phase_done = (cnt_q == WaitLast);
      default:            phase_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lo_nibble_q <= '0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_e       <= 1'b0;
      sf_d        <= '0;
      ready       <= 1'b1;
    end else begin
      // Counter restarts at each phase boundary; it rests at zero while idle.
      if (state_q != StIdle) begin
        cnt_q <= phase_done ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StUSetup;
            cnt_q       <= '0;
            lo_nibble_q <= data_in[3:0];
            lcd_rs      <= rs_in;
            lcd_rw      <= rw_in;
            sf_d        <= data_in[7:4];
            lcd_e       <= 1'b0;
            ready       <= 1'b0;
          end
        end
        StUSetup: begin
          if (phase_done) begin
            state_q <= StUPulse;
            lcd_e   <= 1'b1;
          end
        end
        StUPulse: begin
          if (phase_done) begin
            state_q <= StUHold;
            lcd_e   <= 1'b0;
          end
        end
        StUHold: begin
          if (phase_done) begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (phase_done) begin
            state_q <= StLSetup;
            sf_d    <= lo_nibble_q;
          end
        end
        StLSetup: begin
          if (phase_done) begin
            state_q <= StLPulse;
            lcd_e   <= 1'b1;
          end
        end
        StLPulse: begin
          if (phase_done) begin
            state_q <= StLHold;
            lcd_e   <= 1'b0;
          end
        end
        StLHold: begin
          if (phase_done) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (phase_done) begin
            state_q <= StIdle;
            lcd_rs  <= 1'b0;
            lcd_rw  <= 1'b0;
            sf_d    <= '0;
            ready   <= 1'b1;
          end
        end
        default: begin
          // Unreachable encodings recover to idle.
          state_q <= StIdle;
          cnt_q   <= '0;
          lcd_rs  <= 1'b0;
          lcd_rw  <= 1'b0;
          lcd_e   <= 1'b0;
          sf_d    <= '0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_sender.sv
// Bench for command_sender. Expected outputs come from a cycle-index model: k is the
// number of cycles since the accepting edge (0 = idle), and each output is a plain
// function of k and the captured command.
module tb_command_sender;

  localparam int Busy = 2080;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rs_in;
  logic       rw_in;
  logic [7:0] data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] sf_d;
  logic       ready;

  command_sender dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rs_in   (rs_in),
    .rw_in   (rw_in),
    .data_in (data_in),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .sf_d    (sf_d),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  int         k = 0;
  logic       m_rs = 1'b0;
  logic       m_rw = 1'b0;
  logic [7:0] m_data = 8'h00;

  // Enable-pulse bookkeeping on observed outputs.
  int   pulses = 0;
  logic prev_e = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare after it.
  task automatic step(input logic st, input logic r, input logic [7:0] d, input logic rsv,
                      input logic rwv);
    logic       e_exp;
    logic [3:0] sf_exp;
    start   = st;
    rst     = r;
    data_in = d;
    rs_in   = rsv;
    rw_in   = rwv;
    if (r) begin
      k = 0;
    end else if (k == 0) begin
      if (st) begin
        k      = 1;
        m_rs   = rsv;
        m_rw   = rwv;
        m_data = d;
      end
    end else if (k == Busy) begin
      k = 0;
    end else begin
      k++;
    end
    @(negedge clk);
    e_exp  = ((k >= 3) && (k <= 14)) || ((k >= 68) && (k <= 79));
    sf_exp = (k == 0) ? 4'h0 : ((k <= 65) ? m_data[7:4] : m_data[3:0]);
    check_eq("ready", 32'(ready), 32'(k == 0));
    check_eq("lcd_e", 32'(lcd_e), 32'(e_exp));
    check_eq("sf_d", 32'(sf_d), 32'(sf_exp));
    check_eq("lcd_rs", 32'(lcd_rs), 32'((k == 0) ? 1'b0 : m_rs));
    check_eq("lcd_rw", 32'(lcd_rw), 32'((k == 0) ? 1'b0 : m_rw));
    if (lcd_e && !prev_e) pulses++;
    prev_e = lcd_e;
  endtask

  task automatic rnd_step(input logic st, input logic r);
    step(st, r, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    start   = 1'b0;
    rst     = 1'b0;
    rs_in   = 1'b0;
    rw_in   = 1'b0;
    data_in = 8'h00;

    // Reset then idle with noisy data inputs.
    rnd_step(1'b0, 1'b1);
    rnd_step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) rnd_step(1'b0, 1'b0);

    // Instruction 0x28, data inputs randomised while busy.
    pulses = 0;
    step(1'b1, 1'b0, 8'h28, 1'b0, 1'b0);
    for (int i = 0; i < Busy; i++) rnd_step(1'b0, 1'b0);
    check_eq("pulses_28", 32'(pulses), 32'd2);
    check_eq("ready_2081", 32'(ready), 32'd1);

    // Data write 0xA5 with rs=1.
    pulses = 0;
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < Busy; i++) rnd_step(1'b0, 1'b0);
    check_eq("pulses_a5", 32'(pulses), 32'd2);

    // Start pulsed while busy is ignored; random start noise throughout.
    pulses = 0;
    step(1'b1, 1'b0, 8'hB3, 1'b0, 1'b1);
    for (int c = 1; c < Busy; c++) begin
      if (c == 500) step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
      else rnd_step(1'($urandom_range(3) == 0), 1'b0);
    end
    check_eq("pulses_busy", 32'(pulses), 32'd2);
    rnd_step(1'b0, 1'b0);

    // Reset inside the lower pulse at cycle 70, then start during reset.
    step(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    for (int c = 1; c < 70; c++) rnd_step(1'b0, 1'b0);
    check_eq("e_at_70", 32'(lcd_e), 32'd1);
    rnd_step(1'b0, 1'b1);
    rnd_step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b0);

    // Start held high: back-to-back transactions with one idle cycle between.
    for (int i = 0; i < 2 * (Busy + 1) + 4; i++) rnd_step(1'b1, 1'b0);
    for (int i = 0; i < Busy + 2; i++) rnd_step(1'b0, 1'b0);

    // Random start/reset mix.
    for (int i = 0; i < 6000; i++) begin
      rnd_step(1'($urandom_range(15) == 0), 1'($urandom_range(999) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
